// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and default constants for the counter enable sequencer
//
// Contents:
//   ctrl_state_t       2-bit sequencer state (IDLE, RUN, REPORT)
//   DEFAULT_LEN_WIDTH  default width of run length / issued count
//   DEFAULT_PRESCALE   default enable pulse period when prescaling is built in
//   tick_cnt_width()   width of the prescale phase counter for a given period
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_LEN_WIDTH = 16;
    localparam int DEFAULT_PRESCALE  = 4;

    // Phase counter counts 0..p-1; never narrower than one bit.
    function automatic int tick_cnt_width(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescale tick generator for the enable sequencer (used with COUNTER_ENABLE_CTRL_PRESCALE_EN)
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   clear   in   synchronous clear, asserted on the edge that enters RUN
//   run     in   count while high
//   tick    out  high in the last phase of each PRESCALE-cycle period;
//                the sequencer registers it as the next enable pulse
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int            CW   = tick_cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Phase 0 coincides with the pulse issued on RUN entry, so a tick in
    // phase PRESCALE-1 lands the next pulse exactly PRESCALE cycles later.
    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/counter_enable_ctrl.sv
// rtl/counter_enable_ctrl.sv - run-length enable sequencer driving a downstream counter's enable
//
// Build option: COUNTER_ENABLE_CTRL_PRESCALE_EN
//   defined   -> enable is a one-cycle pulse every PRESCALE cycles during RUN
//   undefined -> enable held high continuously for run_len cycles
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   start         in   burst request, sampled only in IDLE
//   run_len       in   number of enable cycles, sampled with start
//   abort         in   terminate burst, sampled only in RUN
//   enable        out  registered enable to the counter
//   busy          out  high in RUN and REPORT
//   done_val      out  completion status valid
//   done_rdy      in   status consumer ready
//   done_count    out  enable cycles issued in the burst
//   done_aborted  out  burst ended by abort
module counter_enable_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH,
    parameter int PRESCALE  = DEFAULT_PRESCALE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] run_len,
    input  logic                 abort,
    output logic                 enable,
    output logic                 busy,
    output logic                 done_val,
    input  logic                 done_rdy,
    output logic [LEN_WIDTH-1:0] done_count,
    output logic                 done_aborted
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 1) begin : g_width_chk
        $error("counter_enable_ctrl: WIDTH must be >= 1");
    end
    if (PRESCALE < 2) begin : g_prescale_chk
        $error("counter_enable_ctrl: PRESCALE must be >= 2");
    end

    ctrl_state_t          state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] issued_now;
    logic                 launch;
    logic                 last_pulse;
    logic                 next_pulse;

    assign launch     = (state == IDLE) && start && (run_len != '0);
    // Count including the pulse currently on the enable line.
    assign issued_now = issued + LEN_WIDTH'(enable);
    assign last_pulse = enable && (remaining == LEN_WIDTH'(1));

`ifdef COUNTER_ENABLE_CTRL_PRESCALE_EN
    logic tick;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (launch),
        .run   (state == RUN),
        .tick  (tick)
    );

    assign next_pulse = tick;
`else
    assign next_pulse = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            issued       <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done_val     <= 1'b0;
            done_count   <= '0;
            done_aborted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= RUN;
                        remaining <= run_len;
                        issued    <= '0;
                        enable    <= 1'b1;
                        busy      <= 1'b1;
                    end else if (start) begin
                        // Zero-length burst: report immediately, no enable.
                        state        <= REPORT;
                        busy         <= 1'b1;
                        done_val     <= 1'b1;
                        done_count   <= '0;
                        done_aborted <= 1'b0;
                    end
                end

                RUN: begin
                    issued    <= issued_now;
                    remaining <= remaining - LEN_WIDTH'(enable);
                    // Final pulse takes priority over a coincident abort.
                    if (last_pulse || abort) begin
                        state        <= REPORT;
                        enable       <= 1'b0;
                        done_val     <= 1'b1;
                        done_count   <= issued_now;
                        done_aborted <= !last_pulse;
                    end else begin
                        enable <= next_pulse;
                    end
                end

                REPORT: begin
                    if (done_rdy) begin
                        state    <= IDLE;
                        done_val <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// tb/tb_counter_enable_ctrl.sv - self-checking bench for counter_enable_ctrl
module tb_counter_enable_ctrl;

    localparam int LW = 16;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          done_rdy = 1'b1;
    logic [LW-1:0] run_len = '0;
    logic          enable;
    logic          busy;
    logic          done_val;
    logic          done_aborted;
    logic [LW-1:0] done_count;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [LW-1:0] count;
        logic          aborted;
    } status_t;

    status_t sb_q[$];

    int         en_total = 0;
    logic [1:0] ctr;

    always #5 clock = ~clock;

    counter_enable_ctrl #(
        .WIDTH     (2),
        .LEN_WIDTH (LW),
        .PRESCALE  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .run_len      (run_len),
        .abort        (abort),
        .enable       (enable),
        .busy         (busy),
        .done_val     (done_val),
        .done_rdy     (done_rdy),
        .done_count   (done_count),
        .done_aborted (done_aborted)
    );

    // Downstream 2-bit counter and a running count of enable cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) ctr <= 2'd0;
        else if (enable) ctr <= ctr + 2'd1;
    end

    always @(posedge clock) begin
        if (enable) en_total <= en_total + 1;
    end

    // Status monitor: each transfer is popped against the scoreboard.
    always @(negedge clock) begin
        status_t e;
        if (!reset && done_val && done_rdy) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL status_unexpected: got count=%0d aborted=%0d, required no status", done_count, done_aborted);
            end else begin
                e = sb_q.pop_front();
                if (done_count !== e.count || done_aborted !== e.aborted) begin
                    fails++;
                    $display("FAIL status: got count=%0d aborted=%0d, required count=%0d aborted=%0d",
                             done_count, done_aborted, e.count, e.aborted);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        tests++;
        if ({enable, busy, done_val, done_aborted} !== 4'b0000 || done_count !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b busy=%b dv=%b ab=%b cnt=%0d, required all 0",
                     enable, busy, done_val, done_aborted, done_count);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        tests++;
        if ({enable, busy, done_val} !== 3'b000 || ctr !== 2'd0) begin
            fails++;
            $display("FAIL reset_idle: got en=%b busy=%b dv=%b ctr=%0d, required 0", enable, busy, done_val, ctr);
        end
    endtask

    task automatic test_basic();
        int   base, first_en, dv_first, dv_cnt;
        logic busy0, busy6;
        base = en_total; first_en = -1; dv_first = -1; dv_cnt = 0; busy0 = 1'b0; busy6 = 1'b1;
        done_rdy = 1'b1;
        start = 1'b1; run_len = 16'd5;
        sb_q.push_back('{count: 16'd5, aborted: 1'b0});
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (enable && first_en < 0) first_en = c;
            if (done_val) begin
                dv_cnt++;
                if (dv_first < 0) dv_first = c;
            end
            if (c == 0) busy0 = busy;
            if (c == 6) busy6 = busy;
        end
        tests++;
        if (en_total - base != 5) begin
            fails++; $display("FAIL basic_en_cycles: got %0d, required 5", en_total - base);
        end
        tests++;
        if (first_en != 0) begin
            fails++; $display("FAIL basic_first_en: got %0d, required 0", first_en);
        end
        tests++;
        if (dv_first != 5 || dv_cnt != 1) begin
            fails++; $display("FAIL basic_done_timing: got first=%0d n=%0d, required first=5 n=1", dv_first, dv_cnt);
        end
        tests++;
        if (busy0 !== 1'b1 || busy6 !== 1'b0) begin
            fails++; $display("FAIL basic_busy: got rise=%b after=%b, required 1 0", busy0, busy6);
        end
        tests++;
        if (ctr !== 2'd1) begin
            fails++; $display("FAIL basic_counter: got %0d, required 1", ctr);
        end
    endtask

    task automatic test_zero();
        int base, dv_first, dv_cnt;
        base = en_total; dv_first = -1; dv_cnt = 0;
        start = 1'b1; run_len = 16'd0;
        sb_q.push_back('{count: 16'd0, aborted: 1'b0});
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (done_val) begin
                dv_cnt++;
                if (dv_first < 0) dv_first = c;
            end
        end
        tests++;
        if (en_total != base || dv_first != 0 || dv_cnt != 1) begin
            fails++;
            $display("FAIL zero_len: got en=%0d dv_first=%0d dv_n=%0d, required en=0 dv_first=0 dv_n=1",
                     en_total - base, dv_first, dv_cnt);
        end
    endtask

    task automatic test_abort();
        int base;
        base = en_total;
        start = 1'b1; run_len = 16'd10;
        sb_q.push_back('{count: 16'd3, aborted: 1'b1});
        step();
        start = 1'b0;
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clock);
        tests++;
        if (enable !== 1'b0 || done_val !== 1'b1 || done_aborted !== 1'b1) begin
            fails++;
            $display("FAIL abort_edge: got en=%b dv=%b ab=%b, required 0 1 1", enable, done_val, done_aborted);
        end
        repeat (3) step();
        tests++;
        if (en_total - base != 3) begin
            fails++; $display("FAIL abort_en_cycles: got %0d, required 3", en_total - base);
        end
    endtask

    task automatic test_hold();
        int   base;
        logic bad;
        base = en_total; bad = 1'b0;
        done_rdy = 1'b0;
        start = 1'b1; run_len = 16'd4;
        sb_q.push_back('{count: 16'd4, aborted: 1'b0});
        step();
        start = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done_val !== 1'b1 || busy !== 1'b1 || done_count !== 16'd4 || done_aborted !== 1'b0 || enable !== 1'b0) begin
                bad = 1'b1;
                $display("FAIL hold_stable: cycle %0d got dv=%b busy=%b cnt=%0d ab=%b en=%b, required 1 1 4 0 0",
                         i, done_val, busy, done_count, done_aborted, enable);
            end
            #1;
            if (i == 1) begin start = 1'b1; run_len = 16'd7; end
            if (i == 2) start = 1'b0;
        end
        tests++;
        if (bad) fails++;
        step();
        done_rdy = 1'b1;
        @(negedge clock);
        @(negedge clock);
        tests++;
        if (done_val !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_release: got dv=%b busy=%b, required 0 0", done_val, busy);
        end
        repeat (4) step();
        tests++;
        if (en_total - base != 4) begin
            fails++; $display("FAIL hold_ignored_start: got %0d enable cycles, required 4", en_total - base);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        done_rdy = 1'b1;
        start = 1'b1; run_len = 16'd100;
        step();
        start = 1'b0;
        repeat (19) step();
        @(negedge clock);
        tests++;
        if (enable !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL midrun_active: got en=%b busy=%b, required 1 1", enable, busy);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (enable !== 1'b0 || busy !== 1'b0 || done_val !== 1'b0) begin
            fails++; $display("FAIL midrun_async: got en=%b busy=%b dv=%b, required 0 0 0", enable, busy, done_val);
        end
        repeat (2) step();
        reset = 1'b0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clock);
            if (done_val || enable) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL midrun_no_status: got %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = en_total;
        done_rdy = 1'b1;
        run_len = 16'd2;
        start = 1'b1;
        repeat (3) sb_q.push_back('{count: 16'd2, aborted: 1'b0});
        repeat (9) step();
        start = 1'b0;
        repeat (6) step();
        @(negedge clock);
        tests++;
        if (en_total - base != 6) begin
            fails++; $display("FAIL b2b_en_cycles: got %0d, required 6", en_total - base);
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++; $display("FAIL b2b_status_count: got %0d pending, required 0", sb_q.size());
        end
    endtask

`ifdef COUNTER_ENABLE_CTRL_PRESCALE_EN
    task automatic test_prescale();
        logic [13:0] en_mask, dv_mask;
        logic [13:0] en_exp, dv_exp;
        en_mask = '0; dv_mask = '0;
        en_exp = 14'b00000100010001;
        dv_exp = 14'b00001000000000;
        done_rdy = 1'b1;
        start = 1'b1; run_len = 16'd3;
        sb_q.push_back('{count: 16'd3, aborted: 1'b0});
        step();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            en_mask[c] = enable;
            dv_mask[c] = done_val;
        end
        tests++;
        if (en_mask !== en_exp || dv_mask !== dv_exp) begin
            fails++;
            $display("FAIL prescale_pulses: got en=%b dv=%b, required en=%b dv=%b", en_mask, dv_mask, en_exp, dv_exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef COUNTER_ENABLE_CTRL_PRESCALE_EN
        test_prescale();
`endif
        repeat (3) step();
        tests++;
        if (sb_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
